seq_divider_16: RTL
===================

Name: seq_divider_16

Overview:
- Iterative restoring divider producing one quotient bit per clock.
- Sits beside the CLA adder in the KGPminiRISC ALU datapath and serves the DIV/MOD class instructions.
- Each step's trial subtraction is performed as a + ~b + 1, which is the inverse operation of the adder.
- Multi-cycle with a start/done handshake, so the control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 16: operand, quotient and remainder width in bits. Any value ≥ 2 is legal; 16 is the integrated configuration.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- quotient  output  WIDTH  result, held until the next accepted start
- remainder  output  WIDTH  result, held until the next accepted start
- div_by_zero  output  1  set with done when divisor=0; held with the results

Behaviour:
- Reset: while rst=1, force state=IDLE and busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
  - Reset mid-operation aborts the operation; no done pulse follows.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 latches dividend into the quotient shift register Q, latches divisor into D, clears the (WIDTH+1)-bit partial remainder R, sets counter=WIDTH and busy=1.
  - If divisor=0, go to DONE instead of RUN.
  - Otherwise go to RUN.
- RUN, one step per cycle:
  - S = {R[WIDTH-1:0], Q[WIDTH-1]}, a WIDTH+1 bit value.
  - T = S - {0, D}, computed WIDTH+2 bits wide.
  - If T is non-negative: R = T and Q = {Q[WIDTH-2:0], 1}.
  - Otherwise: R = S and Q = {Q[WIDTH-2:0], 0}.
  - counter decrements each step; when the step taken at counter=1 completes, go to DONE.
- DONE (one cycle):
  - Drive quotient=Q and remainder=R[WIDTH-1:0], pulse done=1, busy=0, then return to IDLE.
  - Divide-by-zero case: quotient = all ones, remainder = dividend, div_by_zero=1.
  - On a normal completion div_by_zero=0.
- Latency: start accepted at edge N.
  - Normal operation: done high during cycle N+WIDTH+1, i.e. 17 cycles for WIDTH=16.
  - Divide-by-zero: done high during cycle N+1.
- Handshake:
  - start while busy=1 is ignored; no queuing and no effect on the operation in progress.
  - start asserted during the DONE cycle is ignored; the requester re-asserts it in IDLE.
  - start held high continuously restarts on every IDLE cycle. This is legal, and each operation completes.
- Outputs change only in the DONE cycle and stay stable from done until the next DONE.
- No overflow is possible in unsigned mode. The invariant quotient*divisor + remainder = dividend holds, with remainder < divisor.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement.
  - At start, latch the sign of each operand and the operand magnitudes.
  - The unsigned core runs unchanged.
  - In DONE, negate quotient if the operand signs differ, and give remainder the sign of the dividend. This truncates toward zero.
  - Special case: most-negative / -1 returns quotient = most-negative, remainder=0, div_by_zero=0.
  - Divide-by-zero returns quotient = all ones, remainder = dividend unchanged.
  - Latency is identical to the unsigned build.
- Undefined: unsigned-only operation, with no sign logic synthesized.

Test Plan:
- Reset, then dividend=1000, divisor=7, start one cycle → busy high 16 cycles, done exactly 17 cycles after the accepting edge; quotient=142, remainder=6, div_by_zero=0.
- Edge values: 65535/1 → q=65535, r=0; 3/10 → q=0, r=3; 65535/65535 → q=1, r=0; 32768/3 → q=10922, r=2.
- Divide-by-zero: 5/0 → done one cycle after start; q=16'hFFFF, r=5, div_by_zero=1. A following 9/3 clears the flag, giving q=3, r=0.
- Busy protection: start 1000/7, then at cycle 5 pulse start with 50/5 → result is still 142 r 6, with exactly one done pulse.
- Reset mid-operation: start 414/12, assert rst at cycle 8 → all outputs 0 immediately, no done pulse. After release, 1036/414 → q=2, r=208.
- With SIGNED_DIV_EN defined:
  - -7/2 → q=-3 (16'hFFFD), r=-1 (16'hFFFF).
  - 7/-2 → q=-3, r=1.
  - -32768/-1 → q=16'h8000, r=0.

Source files
------------

// File: rtl/seq_divider_16.sv
// Iterative restoring divider, one quotient bit per clock, with a start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division); the default build is unsigned only.
module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] quot_hold_q, rem_hold_q;
    logic             dz_hold_q;

    logic [WIDTH-1:0] dvd_load, dsr_load;
    logic [WIDTH-1:0] quot_res, rem_res;
    logic [WIDTH:0]   s_w;
    logic [WIDTH+1:0] t_w;
    logic             t_neg;

    // The restored remainder is always below D, so its top bit never carries information out.
    logic unused_r_msb;
    assign unused_r_msb = r_q[WIDTH];

    assign s_w   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign t_w   = {1'b0, s_w} + ~{2'b00, d_q} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign t_neg = t_w[WIDTH+1];

`ifdef SIGNED_DIV_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;

    assign dvd_load = dividend[WIDTH-1] ? -dividend : dividend;
    assign dsr_load = divisor[WIDTH-1]  ? -divisor  : divisor;

    // Divide-by-zero keeps the dividend magnitude in Q, so re-apply its sign for the remainder.
    always_comb begin
        if (dz_q) begin
            quot_res = '1;
            rem_res  = neg_rem_q ? -q_q : q_q;
        end else begin
            quot_res = neg_quot_q ? -q_q : q_q;
            rem_res  = neg_rem_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        end
    end
`else
    assign dvd_load = dividend;
    assign dsr_load = divisor;

    always_comb begin
        if (dz_q) begin
            quot_res = '1;
            rem_res  = q_q;
        end else begin
            quot_res = q_q;
            rem_res  = r_q[WIDTH-1:0];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
`ifdef SIGNED_DIV_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = dvd_load;
                    d_d     = dsr_load;
                    r_d     = '0;
                    cnt_d   = CW'(WIDTH);
                    dz_d    = (divisor == '0);
                    state_d = (divisor == '0) ? DONE : RUN;
`ifdef SIGNED_DIV_EN
                    neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d  = dividend[WIDTH-1];
`endif
                end
            end
            RUN: begin
                r_d   = t_neg ? s_w : t_w[WIDTH:0];
                q_d   = {q_q[WIDTH-2:0], ~t_neg};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
`ifdef SIGNED_DIV_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    // Results are presented live during DONE and captured so they hold until the next DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_hold_q <= '0;
            rem_hold_q  <= '0;
            dz_hold_q   <= 1'b0;
        end else if (state_q == DONE) begin
            quot_hold_q <= quot_res;
            rem_hold_q  <= rem_res;
            dz_hold_q   <= dz_q;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = (state_q == DONE) ? quot_res : quot_hold_q;
    assign remainder   = (state_q == DONE) ? rem_res  : rem_hold_q;
    assign div_by_zero = (state_q == DONE) ? dz_q     : dz_hold_q;

endmodule
